uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's UART transmit path.
- Runs on the 30 MHz system clock. At the default divide of 3125 clocks per bit, it receives at 9600 baud.
- Synchronises the asynchronous rx pin, validates the start bit at mid-bit, samples each data bit at its centre, and checks the stop bit.
- Presents each received byte to a downstream consumer through a valid/ready handshake, with framing-error and overrun reporting.

Parameters:
- CLKS_PER_BIT, 3125: clk30M cycles per bit period (30 MHz / 9600).
- HALF_BIT, CLKS_PER_BIT/2 = 1562: delay from start-edge detection to the start-bit validation sample.
- CNT_W, 12: bit-timer width. Required: 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk30M, input, 1: system clock, 30 MHz. All logic is on the rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- rx, input, 1: serial line. Idle high. Asynchronous to clk30M.
- rx_data, output, 8: received byte, LSB first on the wire. Stable while rx_valid=1.
- rx_valid, output, 1: byte available. Held until accepted.
- rx_ready, input, 1: consumer accepts the byte when rx_valid & rx_ready are both high on a rising edge.
- frame_err, output, 1: one-cycle pulse when a stop bit is sampled low.
- overrun, output, 1: sticky flag; a byte was lost because rx_valid was still pending.
- busy, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock domain, clk30M. Reset rst is asynchronous and active-high.
- Reset values:
  - rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - FSM=IDLE, bit timer=0, bit index=0.
  - Both synchroniser flops and the edge-detect flop = 1.
- Reset mid-frame: the partial byte is discarded and no flag is raised. A line still low after reset is released is not treated as a start bit, because a falling edge is required.
- Input path: rx passes through a 2-flop synchroniser to give rx_s, so the pin-to-rx_s delay is 2 cycles. A third flop, rx_d, is used for falling-edge detection (rx_d=1, rx_s=0).
- FSM IDLE:
  - Bit timer is held at 0.
  - On a falling edge of rx_s (call this cycle E), go to START.
- FSM START:
  - The timer counts up from 0.
  - At cycle E+HALF_BIT, sample rx_s.
  - If rx_s=0, go to DATA with timer=0 and bit index=0.
  - If rx_s=1, the start was a glitch: return to IDLE silently.
- FSM DATA:
  - The timer counts 0..CLKS_PER_BIT-1, then wraps to 0.
  - On each wrap, shift rx_s into the shift register MSB, giving LSB-first assembly.
  - Data bit k (k=0..7) is therefore sampled at E+HALF_BIT+(k+1)*CLKS_PER_BIT.
  - After bit 7, go to STOP.
- FSM STOP:
  - The stop bit is sampled at E+HALF_BIT+9*CLKS_PER_BIT, then the FSM goes to IDLE.
  - Stop bit = 1: the byte is delivered. rx_data and rx_valid update on the next edge (E+HALF_BIT+9*CLKS_PER_BIT+1), subject to the overrun rule below.
  - Stop bit = 0: frame_err=1 for exactly one cycle, the byte is discarded, and rx_valid and rx_data are unchanged.
- Returning to IDLE right after the stop sample lets a back-to-back start edge, half a bit later, be caught.
- Handshake:
  - rx_valid falls on the edge after the cycle where rx_valid & rx_ready are both high.
  - rx_ready while rx_valid=0 has no effect.
- Overrun:
  - A byte delivered while rx_valid=1 and not being accepted in that same cycle is dropped. rx_data keeps the old byte and overrun is set to 1.
  - overrun clears on the next accept.
  - If a delivery and an accept happen in the same cycle, the new byte loads, rx_valid stays 1, and no overrun is flagged.
- Timer arithmetic: unsigned, CNT_W bits. The compare is exact equality, with no rollover beyond CLKS_PER_BIT-1.
- A line held low continuously, i.e. a break, yields one frame_err and then no further activity until rx returns high and falls again.

Test Plan:
- Single byte: send 0xA5 (8N1, 3125 clocks/bit), rx_ready=1 → rx_valid pulses for 1 cycle with rx_data=8'hA5, frame_err=0, overrun=0. busy falls at E+1562+9*3125.
- Glitch: drive rx low for 1000 cycles, then high → busy high for 1562 cycles, then 0. No rx_valid and no frame_err.
- Framing error: send 0x3C with the stop bit driven 0 → frame_err is a 1-cycle pulse, rx_valid stays 0, rx_data is unchanged (8'h00 after reset).
- Overrun: rx_ready=0; send 0x11 then 0x22 back-to-back → rx_data=8'h11, rx_valid=1, overrun=1. Raising rx_ready for 1 cycle → rx_valid=0, overrun=0.
- Back-to-back stream: 0x00, 0xFF, 0x55 with one stop bit each and rx_ready=1 → three rx_valid pulses with the exact values, in order.
- Reset mid-frame: assert rst during bit 4 of 0x81 while rx stays low → all outputs read 0 immediately. After release, no byte and no frame_err until the next falling edge. A following 0x42 is received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver with valid/ready byte output
// Mid-bit start validation, centre sampling, framing-error and overrun reporting.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 3125,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2,
    parameter int CNT_W        = 12
) (
    input  logic       clk30M,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic             sync1, rx_s, rx_d;
    logic [1:0]       prime;
    logic             fall;
    logic             deliver;
    logic             fail;
    logic             accept;

    // rx_d only holds a genuine pin sample three edges after reset; until then
    // a line held low would look like a falling edge against the reset-high flops.
    always_ff @(posedge clk30M or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
            prime <= 2'd0;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
            rx_d  <= rx_s;
            if (prime != 2'd3) begin
                prime <= prime + 2'd1;
            end
        end
    end

    assign fall = (prime == 2'd3) & rx_d & ~rx_s;

    always_ff @(posedge clk30M or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        deliver     = 1'b0;
        fail        = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt   = '0;
                bit_idx_nxt = 3'd0;
                if (fall) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (timer == HALF_LAST) begin
                    timer_nxt   = '0;
                    bit_idx_nxt = 3'd0;
                    state_nxt   = rx_s ? IDLE : DATA;
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            DATA: begin
                if (timer == BIT_LAST) begin
                    timer_nxt = '0;
                    shift_nxt = {rx_s, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            STOP: begin
                // Leaving at mid-stop gives half a bit to catch a back-to-back start edge.
                if (timer == BIT_LAST) begin
                    timer_nxt = '0;
                    state_nxt = IDLE;
                    if (rx_s) begin
                        deliver = 1'b1;
                    end else begin
                        fail = 1'b1;
                    end
                end else begin
                    timer_nxt = timer + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    assign accept = rx_valid & rx_ready;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk30M or posedge rst) begin
        if (rst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= fail;
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (accept) begin
                rx_valid <= 1'b0;
            end
            if (deliver && rx_valid && !rx_ready) begin
                overrun <= 1'b1;
            end else if (accept) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed bench for uart_rx_core
// Short bit period keeps the run small; all timing expectations scale with C.
module tb_uart_rx_core;

    localparam int C = 32;
    localparam int H = C / 2;

    logic       clk30M = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int vectors    = 0;
    int miscompares = 0;
    int busy_cyc   = 0;
    int valid_cyc  = 0;
    int ferr_cyc   = 0;
    logic [7:0] got[$];

    int n0, v0, f0, b0;

    uart_rx_core #(.CLKS_PER_BIT(C), .CNT_W(6)) dut (
        .clk30M   (clk30M),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk30M = ~clk30M;

    always @(negedge clk30M) begin
        if (busy === 1'b1) busy_cyc++;
        if (rx_valid === 1'b1) valid_cyc++;
        if (frame_err === 1'b1) ferr_cyc++;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) got.push_back(rx_data);
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        repeat (C) @(negedge clk30M);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (C) @(negedge clk30M);
        end
        rx = stop_bit;
        repeat (C) @(negedge clk30M);
        rx = 1'b1;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk30M);
        #2 rx_ready = v;
        @(negedge clk30M);
    endtask

    initial begin
        rx = 1'b1;
        rx_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk30M);
        check("rst_data", int'(rx_data), 0);
        check("rst_valid", int'(rx_valid), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk30M);

        // framing error on 0x3C
        f0 = ferr_cyc; v0 = valid_cyc;
        send_byte(8'h3C, 1'b0);
        repeat (4 * C) @(negedge clk30M);
        check("ferr_pulses", ferr_cyc - f0, 1);
        check("ferr_no_valid", valid_cyc - v0, 0);
        check("ferr_data_kept", int'(rx_data), 8'h00);
        check("ferr_low_after", int'(frame_err), 0);

        // single byte 0xA5
        f0 = ferr_cyc; v0 = valid_cyc; b0 = busy_cyc; n0 = got.size();
        send_byte(8'hA5, 1'b1);
        repeat (C) @(negedge clk30M);
        check("single_valid_cycles", valid_cyc - v0, 1);
        check("single_busy_cycles", busy_cyc - b0, H + 9 * C);
        check("single_count", got.size(), n0 + 1);
        check("single_data", int'(got[n0]), 8'hA5);
        check("single_overrun", int'(overrun), 0);
        check("single_no_ferr", ferr_cyc - f0, 0);

        // glitch shorter than half a bit
        f0 = ferr_cyc; v0 = valid_cyc; b0 = busy_cyc;
        rx = 1'b0;
        repeat (10) @(negedge clk30M);
        rx = 1'b1;
        repeat (2 * C) @(negedge clk30M);
        check("glitch_busy_cycles", busy_cyc - b0, H);
        check("glitch_no_valid", valid_cyc - v0, 0);
        check("glitch_no_ferr", ferr_cyc - f0, 0);

        // overrun: two bytes with consumer stalled
        set_ready(1'b0);
        n0 = got.size();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (C) @(negedge clk30M);
        check("ovr_data", int'(rx_data), 8'h11);
        check("ovr_valid", int'(rx_valid), 1);
        check("ovr_flag", int'(overrun), 1);
        set_ready(1'b1);
        set_ready(1'b0);
        check("ovr_accept_valid", int'(rx_valid), 0);
        check("ovr_accept_flag", int'(overrun), 0);
        check("ovr_accepted_byte", int'(got[n0]), 8'h11);
        check("ovr_accept_count", got.size(), n0 + 1);

        // back-to-back stream
        set_ready(1'b1);
        n0 = got.size(); v0 = valid_cyc;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h55, 1'b1);
        repeat (C) @(negedge clk30M);
        check("stream_count", got.size(), n0 + 3);
        check("stream_b0", int'(got[n0]), 8'h00);
        check("stream_b1", int'(got[n0 + 1]), 8'hFF);
        check("stream_b2", int'(got[n0 + 2]), 8'h55);
        check("stream_valid_cycles", valid_cyc - v0, 3);

        // reset during bit 4 of 0x81 with the line low
        rx = 1'b0;
        repeat (C) @(negedge clk30M);
        rx = 1'b1;
        repeat (C) @(negedge clk30M);
        rx = 1'b0;
        repeat (3 * C + H) @(negedge clk30M);
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_data", int'(rx_data), 0);
        check("mid_rst_valid", int'(rx_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ferr", int'(frame_err), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        repeat (3) @(negedge clk30M);
        rst = 1'b0;
        n0 = got.size(); f0 = ferr_cyc; b0 = busy_cyc;
        repeat (3 * C - H) @(negedge clk30M);
        rx = 1'b1;
        repeat (4 * C) @(negedge clk30M);
        check("post_rst_busy", busy_cyc - b0, 0);
        check("post_rst_no_byte", got.size(), n0);
        check("post_rst_no_ferr", ferr_cyc - f0, 0);
        send_byte(8'h42, 1'b1);
        repeat (C) @(negedge clk30M);
        check("post_rst_count", got.size(), n0 + 1);
        check("post_rst_data", int'(got[n0]), 8'h42);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
